// File: rtl/fetch_pkg.sv
// Shared constants and the default fetch entry type for the instruction fetch
// stage. Modules with non-default widths build their own entry of the same shape.
package fetch_pkg;

  localparam int DEFAULT_XLEN = 64;
  localparam int DEFAULT_ILEN = 32;
  localparam int INSTR_BYTES  = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO for fetched {pc, instr} entries.
// Flush empties the queue and wins over a push in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  entry_t                      i_push_data,
  input  logic                        i_pop,
  input  logic                        i_flush,
  output entry_t                      o_head,
  output logic [cnt_width(DEPTH)-1:0] o_count
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_queue DEPTH must be a power of two and at least 2");
  end

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // The caller's credit scheme guarantees a free slot on every push.
  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop && !i_flush && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the PC, issues one request per cycle to a one-cycle imem,
// and buffers responses so decode stalls do not freeze fetch.
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter int              ILEN     = DEFAULT_ILEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr
);

  localparam int CNT_W = cnt_width(DEPTH);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("instruction_fetch_queue RESET_PC must be 4-byte aligned");
  end

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_req_pc;
  logic             r_inflight;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occupancy;
  logic             w_credit;
  logic             w_push;
  logic             w_pop;
  logic [XLEN-1:0]  w_redirect_target;
  entry_t           w_push_entry;
  entry_t           w_head;
  logic             w_unused_low_bits;

  // Entries queued plus the one in flight must never exceed the FIFO size.
  assign w_occupancy = {1'b0, w_count} + (CNT_W + 1)'(r_inflight);
  assign w_credit    = w_occupancy < (CNT_W + 1)'(DEPTH);

  assign imem_req  = !rst && !redirect_valid && w_credit;
  assign imem_addr = r_fetch_pc;

  assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_low_bits = ^redirect_pc[1:0];

  assign w_push       = r_inflight && !redirect_valid;
  assign w_pop        = if_valid && if_ready;
  assign w_push_entry = '{pc: r_req_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_target;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
      end
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  // Head outputs come straight from queue storage; imem_rdata never reaches them.
  assign if_valid = (w_count != '0);
  assign if_pc    = if_valid ? w_head.pc : '0;
  assign if_instr = if_valid ? w_head.instr : ILEN'(NOP_INSTR);

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Drives a DEPTH=4 and a DEPTH=2 fetch queue with shared reset/redirect and
// separate decode-ready streams, checking both against a stream-level model.
module tb_instruction_fetch_queue;

  localparam logic [63:0] RESET_PC = 64'h1000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;

  logic        imem_req   [2];
  logic [63:0] imem_addr  [2];
  logic [31:0] imem_rdata [2];
  logic        if_valid   [2];
  logic        if_ready   [2];
  logic [63:0] if_pc      [2];
  logic [31:0] if_instr   [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference state per DUT: issue cycles of outstanding requests (ring),
  // the PC expected at the head, and the next address expected on imem.
  int          st [2][8];
  int          hd [2];
  int          sz [2];
  logic [63:0] exp_pc    [2];
  logic [63:0] exp_issue [2];

  always #5 clk = ~clk;

  instruction_fetch_queue #(
    .XLEN(64), .ILEN(32), .DEPTH(4), .RESET_PC(RESET_PC)
  ) u_dut4 (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req[0]), .imem_addr(imem_addr[0]), .imem_rdata(imem_rdata[0]),
    .if_valid(if_valid[0]), .if_ready(if_ready[0]),
    .if_pc(if_pc[0]), .if_instr(if_instr[0])
  );

  instruction_fetch_queue #(
    .XLEN(64), .ILEN(32), .DEPTH(2), .RESET_PC(RESET_PC)
  ) u_dut2 (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req[1]), .imem_addr(imem_addr[1]), .imem_rdata(imem_rdata[1]),
    .if_valid(if_valid[1]), .if_ready(if_ready[1]),
    .if_pc(if_pc[1]), .if_instr(if_instr[1])
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[17:2], ~a[17:2]} ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  // One-cycle-latency instruction memory image.
  always @(posedge clk) begin
    imem_rdata[0] <= mem_word(imem_addr[0]);
    imem_rdata[1] <= mem_word(imem_addr[1]);
  end

  function automatic int depth_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic monitor(input int d);
    logic exp_req;
    logic exp_v;
    string p;
    p = $sformatf("d%0d_", d);
    if (rst) begin
      check({p, "req_in_rst"}, imem_req[d], 1'b0);
      sz[d]        = 0;
      hd[d]        = 0;
      exp_pc[d]    = RESET_PC;
      exp_issue[d] = RESET_PC;
    end else begin
      exp_req = !redirect_valid && (sz[d] < depth_of(d));
      check({p, "req"}, imem_req[d], exp_req);
      if (exp_req) check({p, "addr"}, imem_addr[d], exp_issue[d]);

      // A request issued in cycle c is enqueued at the end of c+1.
      exp_v = (sz[d] > 0) && (st[d][hd[d]] <= cyc - 2);
      check({p, "valid"}, if_valid[d], exp_v);
      if (exp_v) begin
        check({p, "pc"}, if_pc[d], exp_pc[d]);
        check({p, "instr"}, if_instr[d], mem_word(exp_pc[d]));
      end else begin
        check({p, "nop"}, if_instr[d], NOP);
      end

      if (redirect_valid) begin
        sz[d]        = 0;
        hd[d]        = 0;
        exp_pc[d]    = {redirect_pc[63:2], 2'b00};
        exp_issue[d] = {redirect_pc[63:2], 2'b00};
      end else begin
        if (exp_v && if_ready[d]) begin
          hd[d]     = (hd[d] + 1) % 8;
          sz[d]     = sz[d] - 1;
          exp_pc[d] = exp_pc[d] + 64'd4;
        end
        if (exp_req) begin
          st[d][(hd[d] + sz[d]) % 8] = cyc;
          sz[d]        = sz[d] + 1;
          exp_issue[d] = exp_issue[d] + 64'd4;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic rv, input logic [63:0] tgt,
                      input logic rdy0, input logic rdy1);
    @(posedge clk);
    #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = tgt;
    if_ready[0]    = rdy0;
    if_ready[1]    = rdy1;
    @(negedge clk);
    monitor(0);
    monitor(1);
    cyc++;
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  initial begin
    if_ready[0] = 1'b1;
    if_ready[1] = 1'b1;

    repeat (3)  step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    // Streaming from RESET_PC.
    repeat (12) step(1'b0, 1'b0, '0, 1'b1, rnd_bit());
    // Decode stall: the deep queue fills and stops requesting.
    repeat (10) step(1'b0, 1'b0, '0, 1'b0, rnd_bit());
    check("fill_req_low", imem_req[0], 1'b0);
    check("fill_valid",   if_valid[0], 1'b1);
    // Free one slot so a request is in flight when the redirect hits.
    step(1'b0, 1'b0, '0, 1'b1, rnd_bit());
    step(1'b0, 1'b0, '0, 1'b0, rnd_bit());
    step(1'b0, 1'b1, 64'h2002, 1'b0, rnd_bit());
    repeat (8)  step(1'b0, 1'b0, '0, 1'b1, rnd_bit());
    // Back-to-back redirects: only the second target survives.
    step(1'b0, 1'b1, 64'h3000, 1'b1, rnd_bit());
    step(1'b0, 1'b1, 64'h4000, 1'b1, rnd_bit());
    repeat (8)  step(1'b0, 1'b0, '0, 1'b1, rnd_bit());
    // Reset mid-stream with a request in flight.
    step(1'b1, 1'b0, '0, 1'b1, rnd_bit());
    repeat (8)  step(1'b0, 1'b0, '0, 1'b1, rnd_bit());
    // PC wraps silently at the top of the address space.
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, rnd_bit());
    repeat (8)  step(1'b0, 1'b0, '0, 1'b1, rnd_bit());

    // Randomized traffic: sporadic redirects, rare resets, random ready.
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic        rv;
      logic [63:0] tgt;
      r   = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      tgt = {32'($urandom), 32'($urandom)};
      step(r, rv, tgt, ($urandom_range(0, 3) != 0), rnd_bit());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
